mypwm_core: RTL and testbench

PWM generator core for the myPWM AXI4-Lite peripheral. It sits directly downstream of the AXI4-Lite slave register file and consumes four registers: control at 0x0, period at 0x4, duty at 0x8 and prescale at 0xC. It produces a glitch-free PWM waveform with configurable period, duty and clock prescale, plus a per-period tick and a counter readback value. Period, duty and prescale are shadowed, so a software write takes effect only at a period boundary.

---
 rtl/mypwm_core.sv | 100 ++++++++++
 tb/tb_mypwm_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mypwm_core.sv
// PWM generator core: prescaled period counter with shadowed period/duty/prescale,
// registered PWM output, per-period tick and counter readback.
module mypwm_core #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 ctrl_en_i,
    input  logic                 ctrl_inv_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] duty_i,
    input  logic [CNT_WIDTH-1:0] prescale_i,
    input  logic                 update_i,
    output logic                 pwm_o,
    output logic                 period_tick_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] pre_cnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] per_sh;
    logic [CNT_WIDTH-1:0] duty_sh;
    logic [CNT_WIDTH-1:0] pre_sh;
    logic                 pending;
    logic                 en_q;
    logic                 pwm_q;
    logic                 tick_q;

    logic tick;
    logic bnd;
    logic raw;
    logic load_sh;

    always_comb begin
        tick    = (pre_cnt == pre_sh);
        bnd     = tick && (cnt == per_sh);
        raw     = (cnt < duty_sh);
        // A pulse coinciding with the boundary loads immediately, without going through pending.
        load_sh = bnd && (pending || update_i);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pre_cnt <= '0;
            cnt     <= '0;
            per_sh  <= '0;
            duty_sh <= '0;
            pre_sh  <= '0;
            pending <= 1'b0;
            en_q    <= 1'b0;
            pwm_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else if (!en_q) begin
            pre_cnt <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            pwm_q   <= ctrl_inv_i;
            tick_q  <= 1'b0;
            if (ctrl_en_i) begin
                per_sh  <= period_i;
                duty_sh <= duty_i;
                pre_sh  <= prescale_i;
                en_q    <= 1'b1;
            end
        end else if (!ctrl_en_i) begin
            en_q    <= 1'b0;
            pre_cnt <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            pwm_q   <= ctrl_inv_i;
            tick_q  <= 1'b0;
        end else begin
            pwm_q  <= raw ^ ctrl_inv_i;
            tick_q <= bnd;
            pre_cnt <= tick ? '0 : pre_cnt + ONE;
            if (bnd) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + ONE;
            end
            if (load_sh) begin
                per_sh  <= period_i;
                duty_sh <= duty_i;
                pre_sh  <= prescale_i;
                pending <= 1'b0;
            end else if (update_i) begin
                pending <= 1'b1;
            end
        end
    end

    assign pwm_o         = pwm_q;
    assign period_tick_o = tick_q;
    assign cnt_o         = cnt;
    assign busy_o        = en_q;

endmodule

// File: tb/tb_mypwm_core.sv
// Self-checking bench for mypwm_core: table of PWM shapes, hand sequences for
// shadowing/stop/reset, and random stimulus against a position-in-period model.
module tb_mypwm_core;

    logic        ACLK       = 1'b0;
    logic        ARESETN    = 1'b0;
    logic        ctrl_en_i  = 1'b0;
    logic        ctrl_inv_i = 1'b0;
    logic [31:0] period_i   = '0;
    logic [31:0] duty_i     = '0;
    logic [31:0] prescale_i = '0;
    logic        update_i   = 1'b0;
    logic        pwm_o;
    logic        period_tick_o;
    logic [31:0] cnt_o;
    logic        busy_o;

    mypwm_core #(.CNT_WIDTH(32)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ctrl_en_i     (ctrl_en_i),
        .ctrl_inv_i    (ctrl_inv_i),
        .period_i      (period_i),
        .duty_i        (duty_i),
        .prescale_i    (prescale_i),
        .update_i      (update_i),
        .pwm_o         (pwm_o),
        .period_tick_o (period_tick_o),
        .cnt_o         (cnt_o),
        .busy_o        (busy_o)
    );

    always #5 ACLK = ~ACLK;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Model: the period is a flat run of (per+1)*(pre+1) cycles; the main count
    // is the position divided by the prescale length.
    bit              m_en;
    bit              m_pend;
    logic [31:0]     m_per;
    logic [31:0]     m_duty;
    logic [31:0]     m_pre;
    longint unsigned m_pos;
    bit              e_pwm;
    bit              e_tick;

    function automatic void model_reset();
        m_en = 0; m_pend = 0; m_per = '0; m_duty = '0; m_pre = '0;
        m_pos = 0; e_pwm = 0; e_tick = 0;
    endfunction

    function automatic void model_load();
        m_per = period_i; m_duty = duty_i; m_pre = prescale_i;
    endfunction

    function automatic longint unsigned model_cnt();
        return m_pos / (64'(m_pre) + 64'd1);
    endfunction

    function automatic void model_edge();
        longint unsigned len;
        len = (64'(m_per) + 64'd1) * (64'(m_pre) + 64'd1);
        if (!m_en) begin
            e_pwm = ctrl_inv_i; e_tick = 0;
            if (ctrl_en_i) begin
                model_load(); m_en = 1; m_pos = 0; m_pend = 0;
            end
        end else if (!ctrl_en_i) begin
            m_en = 0; m_pos = 0; m_pend = 0; e_pwm = ctrl_inv_i; e_tick = 0;
        end else begin
            e_pwm  = (model_cnt() < 64'(m_duty)) ^ ctrl_inv_i;
            e_tick = (m_pos == len - 1);
            if (e_tick) begin
                m_pos = 0;
                if (m_pend || update_i) begin
                    model_load(); m_pend = 0;
                end
            end else begin
                m_pos++;
                if (update_i) m_pend = 1;
            end
        end
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_all();
        chk("pwm_o", 64'(pwm_o), 64'(e_pwm));
        chk("period_tick_o", 64'(period_tick_o), 64'(e_tick));
        chk("cnt_o", 64'(cnt_o), model_cnt());
        chk("busy_o", 64'(busy_o), 64'(m_en));
    endfunction

    function automatic void check_zero(input string tag);
        chk({tag, "_pwm"}, 64'(pwm_o), 64'd0);
        chk({tag, "_tick"}, 64'(period_tick_o), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endfunction

    task automatic step();
        model_edge();
        @(posedge ACLK);
        #1;
        check_all();
    endtask

    task automatic wait_tick(input int unsigned limit);
        bit seen;
        seen = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            step();
            if (period_tick_o) begin
                seen = 1;
                break;
            end
        end
        chk("tick_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_cnt(input logic [31:0] v, input int unsigned limit);
        bit seen;
        seen = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            if (cnt_o == v) begin
                seen = 1;
                break;
            end
            step();
        end
        chk("cnt_timeout", 64'(seen), 64'd1);
    endtask

    // One full period starting right after a tick: counts high samples and ticks.
    task automatic window(input int unsigned len, output int unsigned highs,
                          output int unsigned ticks, output bit last);
        highs = 0; ticks = 0; last = 0;
        for (int unsigned i = 0; i < len; i++) begin
            step();
            highs += 32'(pwm_o);
            ticks += 32'(period_tick_o);
            last = period_tick_o;
        end
    endtask

    typedef struct {
        logic [31:0] per;
        logic [31:0] duty;
        logic [31:0] pre;
        logic        inv;
        int unsigned exp_high;
        int unsigned exp_len;
    } row_t;

    row_t rows[7];

    initial begin
        int unsigned highs, ticks;
        bit          last;

        rows[0] = '{per: 9, duty: 3,  pre: 0, inv: 0, exp_high: 3,  exp_len: 10};
        rows[1] = '{per: 9, duty: 3,  pre: 1, inv: 0, exp_high: 6,  exp_len: 20};
        rows[2] = '{per: 9, duty: 0,  pre: 0, inv: 0, exp_high: 0,  exp_len: 10};
        rows[3] = '{per: 9, duty: 12, pre: 0, inv: 0, exp_high: 10, exp_len: 10};
        rows[4] = '{per: 9, duty: 3,  pre: 0, inv: 1, exp_high: 7,  exp_len: 10};
        rows[5] = '{per: 0, duty: 1,  pre: 0, inv: 0, exp_high: 1,  exp_len: 1};
        rows[6] = '{per: 4, duty: 2,  pre: 2, inv: 1, exp_high: 9,  exp_len: 15};

        model_reset();
        #195;
        check_zero("reset");
        #7;
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) step();

        foreach (rows[r]) begin
            ctrl_en_i = 1'b0;
            step();
            period_i   = rows[r].per;
            duty_i     = rows[r].duty;
            prescale_i = rows[r].pre;
            ctrl_inv_i = rows[r].inv;
            ctrl_en_i  = 1'b1;
            wait_tick(3 * rows[r].exp_len + 10);
            for (int k = 0; k < 2; k++) begin
                window(rows[r].exp_len, highs, ticks, last);
                chk($sformatf("row%0d_high", r), 64'(highs), 64'(rows[r].exp_high));
                chk($sformatf("row%0d_ticks", r), 64'(ticks), 64'd1);
                chk($sformatf("row%0d_last_tick", r), 64'(last), 64'd1);
            end
        end

        // Shadowed duty change mid-period, then an update landing on the boundary.
        ctrl_en_i = 1'b0; ctrl_inv_i = 1'b0;
        step();
        period_i = 9; duty_i = 3; prescale_i = 0; ctrl_en_i = 1'b1;
        wait_tick(40);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (cnt_o == 4) begin
                duty_i = 7; update_i = 1'b1;
            end
            step();
            update_i = 1'b0;
            highs += 32'(pwm_o);
        end
        chk("shadow_old_period", 64'(highs), 64'd3);
        chk("shadow_old_tick", 64'(period_tick_o), 64'd1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (cnt_o == 9) begin
                duty_i = 5; update_i = 1'b1;
            end
            step();
            update_i = 1'b0;
            highs += 32'(pwm_o);
        end
        chk("shadow_new_period", 64'(highs), 64'd7);
        window(10, highs, ticks, last);
        chk("bnd_update_period", 64'(highs), 64'd5);
        chk("bnd_update_tick", 64'(last), 64'd1);

        // Stop at cnt=5 with inverted polarity, then restart with new registers.
        wait_cnt(5, 20);
        ctrl_en_i = 1'b0; ctrl_inv_i = 1'b1;
        step();
        chk("stop_cnt", 64'(cnt_o), 64'd0);
        chk("stop_busy", 64'(busy_o), 64'd0);
        chk("stop_pwm", 64'(pwm_o), 64'd1);
        ticks = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            ticks += 32'(period_tick_o);
        end
        chk("stop_no_tick", 64'(ticks), 64'd0);
        ctrl_inv_i = 1'b0; period_i = 5; duty_i = 2; ctrl_en_i = 1'b1;
        step();
        chk("restart_busy", 64'(busy_o), 64'd1);
        step();
        chk("restart_first_pwm", 64'(pwm_o), 64'd1);
        wait_tick(20);
        window(6, highs, ticks, last);
        chk("restart_high", 64'(highs), 64'd2);

        // Asynchronous reset in the middle of a period.
        wait_cnt(3, 20);
        #2;
        ARESETN = 1'b0;
        #1;
        model_reset();
        check_zero("async_reset");
        @(posedge ACLK);
        #1;
        check_zero("reset_held");
        #3;
        ARESETN = 1'b1;
        ctrl_en_i = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            update_i = 1'b0;
            if (r < 2) begin
                ctrl_en_i = ~ctrl_en_i;
            end else if (r < 5) begin
                ctrl_inv_i = ~ctrl_inv_i;
            end else if (r < 15) begin
                period_i   = $urandom_range(0, 7);
                duty_i     = $urandom_range(0, 9);
                prescale_i = $urandom_range(0, 3);
                update_i   = 1'b1;
            end else if (r < 40 && !ctrl_en_i) begin
                ctrl_en_i = 1'b1;
            end
            step();
        end
        update_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
